// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage (master) and the multi-cycle divider (slave).
interface div_unit_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring shift-subtract divider, one quotient bit per cycle; result = {remainder, quotient}.
// Define DIV_SKIP_EN to finish in one cycle when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StByZero, StBusy, StDone} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   lo_q;
  logic [DATA_W-1:0]   dsr_q;
  logic                neg_a_q;
  logic                neg_b_q;

  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   lo_nxt;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;
`ifdef DIV_SKIP_EN
  logic [DATA_W-1:0]   skip_rem;
`endif

  always_comb begin
    mag_a    = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    mag_b    = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    // Partial remainder is always below the divisor, so one extra bit holds the shifted value.
    rem_sh   = {rem_q, lo_q[DATA_W-1]};
    diff     = rem_sh - {1'b0, dsr_q};
    rem_nxt  = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
    lo_nxt   = {lo_q[DATA_W-2:0], ~diff[DATA_W]};
    // Sign flags are only latched for signed ops, so they gate the fix-up on their own.
    quot_fix = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    rem_fix  = neg_a_q ? -rem_q : rem_q;
`ifdef DIV_SKIP_EN
    skip_rem = neg_a_q ? -lo_q : lo_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rem_q        <= '0;
      lo_q         <= '0;
      dsr_q        <= '0;
      neg_a_q      <= 1'b0;
      neg_b_q      <= 1'b0;
      bus.ready_o  <= 1'b0;
      bus.result_o <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          bus.ready_o  <= 1'b0;
          bus.result_o <= '0;
          if (bus.start_i && !bus.annul_i) begin
            neg_a_q <= bus.signed_div_i & bus.opdata1_i[DATA_W-1];
            neg_b_q <= bus.signed_div_i & bus.opdata2_i[DATA_W-1];
            lo_q    <= mag_a;
            dsr_q   <= mag_b;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= (bus.opdata2_i == '0) ? StByZero : StBusy;
          end
        end
        StByZero: begin
          if (cnt_q == CntW'(1)) begin
            state_q      <= StDone;
            bus.ready_o  <= 1'b1;
            bus.result_o <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBusy: begin
          if (bus.annul_i) begin
            state_q <= StIdle;
`ifdef DIV_SKIP_EN
          end else if (cnt_q == '0 && lo_q < dsr_q) begin
            state_q      <= StDone;
            bus.ready_o  <= 1'b1;
            bus.result_o <= {skip_rem, {DATA_W{1'b0}}};
`endif
          end else if (cnt_q == CntW'(DATA_W)) begin
            state_q      <= StDone;
            bus.ready_o  <= 1'b1;
            bus.result_o <= {rem_fix, quot_fix};
          end else begin
            rem_q <= rem_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (!bus.start_i) begin
            state_q      <= StIdle;
            bus.ready_o  <= 1'b0;
            bus.result_o <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {rem, quot} and latency, a monitor pops on ready_o.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int unsigned e0;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic prev_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sd, q, r;
    if (b == 32'd0) return 64'd0;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sd = sgn ? longint'($signed(b)) : longint'(b);
    q  = sa / sd;
    r  = sa % sd;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int unsigned ref_lat(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
`ifdef DIV_SKIP_EN
    longint sa, sd;
`endif
    if (b == 32'd0) return 2;
`ifdef DIV_SKIP_EN
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sd = sgn ? longint'($signed(b)) : longint'(b);
    if (sa < 0) sa = -sa;
    if (sd < 0) sd = -sd;
    if (sa < sd) return 1;
`endif
    return 33;
  endfunction

  always @(negedge clk) begin
    if (bus.ready_o && !prev_rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 64'(bus.ready_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result_o, e.res);
        check("latency", 64'(cyc - e.e0), 64'(e.lat));
      end
    end
    prev_rdy = bus.ready_o;
  end

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit rst_in_done);
    exp_t e;
    bit   seen;
    @(posedge clk); #1;
    e.res = ref_div(sgn, a, b);
    e.lat = ref_lat(sgn, a, b);
    e.e0  = cyc + 1;
    sb.push_back(e);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    // Operands are captured; later changes must be ignored.
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom_range(0, 1) ? 32'd0 : $urandom;
    bus.signed_div_i = 1'($urandom_range(0, 1));
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ready_o;
    end
    if (!seen) begin
      check("ready_timeout", 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_back());
      bus.start_i = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
    end else if (rst_in_done) begin
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_done_ready", 64'(bus.ready_o), 64'd0);
      check("rst_done_result", bus.result_o, 64'd0);
      rst = 1'b1;
      bus.start_i = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        @(posedge clk); #1;
        bus.annul_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("hold_ready", 64'(bus.ready_o), 64'd1);
        check("hold_result", bus.result_o, e.res);
      end
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("release_ready", 64'(bus.ready_o), 64'd0);
      check("release_result", bus.result_o, 64'd0);
    end
  endtask

  task automatic run_annul();
    bit any_rdy;
    @(posedge clk); #1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    any_rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      any_rdy |= bus.ready_o;
    end
    check("annul_no_ready", 64'(any_rdy), 64'd0);
  endtask

  task automatic run_rst_busy();
    @(posedge clk); #1;
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFF_F000;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy_ready", 64'(bus.ready_o), 64'd0);
    check("rst_busy_result", bus.result_o, 64'd0);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    rst = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    rst = 1'b1;

    // start with annul in IDLE must be ignored
    @(posedge clk); #1;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    bus.annul_i   = 1'b0;

    run_op(1'b0, 32'd100,        32'd7,        1'b0);
    run_op(1'b1, 32'hFFFF_FFF9,  32'd2,        1'b0);
    run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'd12345,      32'd0,        1'b0);
    run_op(1'b1, 32'hFFFF_FFFB,  32'd0,        1'b0);
    run_op(1'b0, 32'd5,          32'd9,        1'b0);
    run_op(1'b1, 32'hFFFF_FFFD,  32'd8,        1'b0);
    run_op(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
    run_annul();
    run_op(1'b0, 32'hFFFF_FFFF,  32'h10,       1'b0);
    run_rst_busy();
    run_op(1'b1, 32'd77,         32'hFFFF_FFF6, 1'b1);
    run_op(1'b0, 32'd1000,       32'd33,       1'b0);

    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = 32'd0; end
        1:       begin a = $urandom_range(0, 20); b = $urandom_range(1, 40); end
        2:       begin a = $urandom; b = $urandom_range(1, 255); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      if (s && $urandom_range(0, 1) == 1) a = -a;
      run_op(s, a, b, 1'b0);
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
